// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back stage encodings and the load misalignment predicate
package wb_pkg;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_MEM  = 2'b01;
    localparam logic [1:0] MTR_LINK = 2'b10;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    // Unknown load types behave as lw, so they need word alignment too.
    function automatic logic load_is_misaligned(input logic [2:0] load_type, input logic [1:0] addr);
        logic mis;
        case (load_type)
            LD_B, LD_BU: mis = 1'b0;
            LD_H, LD_HU: mis = addr[0];
            default:     mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - selects the addressed byte/half of a load word and sign/zero-extends it
module load_extender
    import wb_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_type,
    output logic [31:0] ext_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (addr)
            2'd0:    lane_byte = raw_word[7:0];
            2'd1:    lane_byte = raw_word[15:8];
            2'd2:    lane_byte = raw_word[23:16];
            default: lane_byte = raw_word[31:24];
        endcase
        lane_half = addr[1] ? raw_word[31:16] : raw_word[15:0];
    end

    always_comb begin
        case (load_type)
            LD_B:    ext_data = {{24{lane_byte[7]}}, lane_byte};
            LD_BU:   ext_data = {24'd0, lane_byte};
            LD_H:    ext_data = {{16{lane_half[15]}}, lane_half};
            LD_HU:   ext_data = {16'd0, lane_half};
            default: ext_data = raw_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, write-back select and retire counter; WB_FWD_BYPASS_EN adds a forwarding tap
module writeback_stage
    import wb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_RegWrite,
    input  logic [4:0]       mem_Write_register,
    input  logic [1:0]       mem_MemtoReg,
    input  logic [2:0]       mem_LoadType,
    input  logic [31:0]      mem_ALU_out,
    input  logic [31:0]      mem_Read_data,
    input  logic [31:0]      mem_PC_plus4,
`ifdef WB_FWD_BYPASS_EN
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic             fwd_valid,
    output logic [4:0]       fwd_reg,
    output logic [31:0]      fwd_data,
    output logic             rs_hit,
    output logic             rt_hit,
`endif
    output logic             RegWrite,
    output logic [4:0]       Write_register,
    output logic [31:0]      Write_data,
    output logic             load_misalign,
    output logic [CNT_W-1:0] retired
);

    logic        wb_valid;
    logic        wb_RegWrite;
    logic [4:0]  wb_Write_register;
    logic [1:0]  wb_MemtoReg;
    logic [2:0]  wb_LoadType;
    logic [31:0] wb_ALU_out;
    logic [31:0] wb_Read_data;
    logic [31:0] wb_PC_plus4;
    logic [31:0] load_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid          <= 1'b0;
            wb_RegWrite       <= 1'b0;
            wb_Write_register <= 5'd0;
            wb_MemtoReg       <= 2'd0;
            wb_LoadType       <= 3'd0;
            wb_ALU_out        <= 32'd0;
            wb_Read_data      <= 32'd0;
            wb_PC_plus4       <= 32'd0;
            retired           <= '0;
        end else begin
            if (flush) begin
                wb_valid <= 1'b0;
            end else if (!stall) begin
                wb_valid          <= mem_valid;
                wb_RegWrite       <= mem_RegWrite;
                wb_Write_register <= mem_Write_register;
                wb_MemtoReg       <= mem_MemtoReg;
                wb_LoadType       <= mem_LoadType;
                wb_ALU_out        <= mem_ALU_out;
                wb_Read_data      <= mem_Read_data;
                wb_PC_plus4       <= mem_PC_plus4;
            end
            // An instruction retires when it leaves WB, which a stall prevents.
            if (wb_valid && !stall)
                retired <= retired + 1'b1;
        end
    end

    load_extender u_load_extender (
        .raw_word  (wb_Read_data),
        .addr      (wb_ALU_out[1:0]),
        .load_type (wb_LoadType),
        .ext_data  (load_value)
    );

    always_comb begin
        load_misalign  = wb_valid && (wb_MemtoReg == MTR_MEM)
                         && load_is_misaligned(wb_LoadType, wb_ALU_out[1:0]);
        RegWrite       = wb_valid && wb_RegWrite && (wb_Write_register != 5'd0) && !load_misalign;
        Write_register = wb_valid ? wb_Write_register : 5'd0;
        Write_data     = 32'd0;
        if (wb_valid) begin
            case (wb_MemtoReg)
                MTR_MEM:  Write_data = load_value;
                MTR_LINK: Write_data = wb_PC_plus4;
                default:  Write_data = wb_ALU_out;
            endcase
        end
    end

`ifdef WB_FWD_BYPASS_EN
    assign fwd_valid = RegWrite;
    assign fwd_reg   = Write_register;
    assign fwd_data  = Write_data;
    assign rs_hit    = RegWrite && (rs_addr == Write_register);
    assign rt_hit    = RegWrite && (rt_addr == Write_register);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage (CNT_W=4), covers WB_FWD_BYPASS_EN when defined
module tb_writeback_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, stall, flush;
    logic          mem_valid, mem_RegWrite;
    logic [4:0]    mem_Write_register;
    logic [1:0]    mem_MemtoReg;
    logic [2:0]    mem_LoadType;
    logic [31:0]   mem_ALU_out, mem_Read_data, mem_PC_plus4;
    logic          RegWrite, load_misalign;
    logic [4:0]    Write_register;
    logic [31:0]   Write_data;
    logic [CW-1:0] retired;
`ifdef WB_FWD_BYPASS_EN
    logic [4:0]    rs_addr, rt_addr, fwd_reg;
    logic          fwd_valid, rs_hit, rt_hit;
    logic [31:0]   fwd_data;
`endif

    writeback_stage #(.CNT_W(CW)) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .flush              (flush),
        .mem_valid          (mem_valid),
        .mem_RegWrite       (mem_RegWrite),
        .mem_Write_register (mem_Write_register),
        .mem_MemtoReg       (mem_MemtoReg),
        .mem_LoadType       (mem_LoadType),
        .mem_ALU_out        (mem_ALU_out),
        .mem_Read_data      (mem_Read_data),
        .mem_PC_plus4       (mem_PC_plus4),
`ifdef WB_FWD_BYPASS_EN
        .rs_addr            (rs_addr),
        .rt_addr            (rt_addr),
        .fwd_valid          (fwd_valid),
        .fwd_reg            (fwd_reg),
        .fwd_data           (fwd_data),
        .rs_hit             (rs_hit),
        .rt_hit             (rt_hit),
`endif
        .RegWrite           (RegWrite),
        .Write_register     (Write_register),
        .Write_data         (Write_data),
        .load_misalign      (load_misalign),
        .retired            (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [4:0]    wr;
        logic [31:0]   wd;
        logic          mis;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_valid = 1'b0;
    logic [CW-1:0] m_ret   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one MEM-stage slot, predicts the WB outputs after the edge, then compares.
    task automatic send(input logic v, input logic rw, input logic [4:0] dst, input logic [1:0] mtr,
                        input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] pc4, input logic st, input logic fl,
                        input logic erw, input logic [4:0] ewr, input logic [31:0] ewd, input logic emis);
        exp_t e;
        mem_valid = v; mem_RegWrite = rw; mem_Write_register = dst; mem_MemtoReg = mtr;
        mem_LoadType = lt; mem_ALU_out = alu; mem_Read_data = rd; mem_PC_plus4 = pc4;
        stall = st; flush = fl;
        if (m_valid && !st) m_ret++;
        if (fl) m_valid = 1'b0;
        else if (!st) m_valid = v;
        sb.push_back('{rw: erw, wr: ewr, wd: ewd, mis: emis, ret: m_ret});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
        check("Write_register", {27'd0, Write_register}, {27'd0, e.wr});
        if (!e.mis) check("Write_data", Write_data, e.wd);
        check("load_misalign", {31'd0, load_misalign}, {31'd0, e.mis});
        check("retired", {{(32-CW){1'b0}}, retired}, {{(32-CW){1'b0}}, e.ret});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        m_valid = 1'b0;
        m_ret   = '0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_RegWrite = 1'b0; mem_Write_register = 5'd0; mem_MemtoReg = 2'd0;
        mem_LoadType = 3'd0; mem_ALU_out = 32'd0; mem_Read_data = 32'd0; mem_PC_plus4 = 32'd0;
`ifdef WB_FWD_BYPASS_EN
        rs_addr = 5'd0; rt_addr = 5'd0;
`endif
        @(posedge clk); #1;
        check("rst RegWrite", {31'd0, RegWrite}, 32'd0);
        check("rst Write_register", {27'd0, Write_register}, 32'd0);
        check("rst Write_data", Write_data, 32'd0);
        check("rst load_misalign", {31'd0, load_misalign}, 32'd0);
        check("rst retired", {{(32-CW){1'b0}}, retired}, 32'd0);
        reset = 1'b0;

        // loads: lanes, halves, extension, misalignment
        send(1, 1, 5'd8,  2'b01, 3'b001, 32'h1003, 32'h80FF_1234, 0, 0, 0, 1, 5'd8,  32'hFFFF_FF80, 0);
        send(1, 1, 5'd9,  2'b01, 3'b100, 32'h2002, 32'h9ABC_5678, 0, 0, 0, 1, 5'd9,  32'h0000_9ABC, 0);
        send(1, 1, 5'd10, 2'b01, 3'b011, 32'h2001, 32'h9ABC_5678, 0, 0, 0, 0, 5'd10, 32'h0, 1);
        send(1, 1, 5'd11, 2'b01, 3'b010, 32'h1000, 32'h80FF_1234, 0, 0, 0, 1, 5'd11, 32'h0000_0034, 0);
        send(1, 1, 5'd12, 2'b01, 3'b001, 32'h1002, 32'h80FF_1234, 0, 0, 0, 1, 5'd12, 32'hFFFF_FFFF, 0);
        send(1, 1, 5'd13, 2'b01, 3'b011, 32'h1002, 32'h9ABC_5678, 0, 0, 0, 1, 5'd13, 32'hFFFF_9ABC, 0);
        send(1, 1, 5'd14, 2'b01, 3'b011, 32'h1000, 32'h9ABC_5678, 0, 0, 0, 1, 5'd14, 32'h0000_5678, 0);
        send(1, 1, 5'd15, 2'b01, 3'b000, 32'h1004, 32'hCAFE_F00D, 0, 0, 0, 1, 5'd15, 32'hCAFE_F00D, 0);
        send(1, 1, 5'd16, 2'b01, 3'b000, 32'h1002, 32'hCAFE_F00D, 0, 0, 0, 0, 5'd16, 32'h0, 1);
        send(1, 1, 5'd17, 2'b01, 3'b111, 32'h1000, 32'h1357_2468, 0, 0, 0, 1, 5'd17, 32'h1357_2468, 0);
        // link, $0, reserved MemtoReg, bubble
        send(1, 1, 5'd31, 2'b10, 3'b000, 32'h55, 32'h11, 32'h0040_0008, 0, 0, 1, 5'd31, 32'h0040_0008, 0);
        send(1, 1, 5'd0,  2'b00, 3'b000, 32'h77, 32'h11, 32'h0, 0, 0, 0, 5'd0, 32'h77, 0);
        send(1, 1, 5'd3,  2'b11, 3'b000, 32'hDEAD, 32'h11, 32'h99, 0, 0, 1, 5'd3, 32'hDEAD, 0);
        send(1, 0, 5'd4,  2'b00, 3'b000, 32'hBEEF, 32'h0, 32'h0, 0, 0, 0, 5'd4, 32'hBEEF, 0);
        send(0, 1, 5'd5,  2'b00, 3'b000, 32'h1111, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0);

        // stall three cycles with changing inputs, then flush while stalled
        send(1, 1, 5'd12, 2'b00, 3'b000, 32'hABCD, 32'h0, 32'h0, 0, 0, 1, 5'd12, 32'hABCD, 0);
        for (int i = 0; i < 3; i++)
            send(1, 1, 5'd20 + 5'(i), 2'b00, 3'b000, $urandom, $urandom, 32'h0, 1, 0, 1, 5'd12, 32'hABCD, 0);
        send(1, 1, 5'd21, 2'b00, 3'b000, 32'h4444, 32'h0, 32'h0, 1, 1, 0, 5'd0, 32'h0, 0);
        send(0, 0, 5'd0,  2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0);

        // counter wrap: 16 commits from reset return retired to 0
        do_reset();
        for (int i = 0; i < 17; i++)
            send(1, 1, 5'd1, 2'b00, 3'b000, 32'(i), 32'h0, 32'h0, 0, 0, 1, 5'd1, 32'(i), 0);
        check("retired wrap", {{(32-CW){1'b0}}, retired}, 32'd0);

`ifdef WB_FWD_BYPASS_EN
        rs_addr = 5'd5; rt_addr = 5'd0;
        send(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'h1234, 0);
        check("rs_hit", {31'd0, rs_hit}, 32'd1);
        check("rt_hit", {31'd0, rt_hit}, 32'd0);
        check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("fwd_reg", {27'd0, fwd_reg}, 32'd5);
        check("fwd_data", fwd_data, 32'h1234);
`endif

        // reset in the middle of a valid write discards it immediately
        send(1, 1, 5'd7, 2'b00, 3'b000, 32'h7777, 32'h0, 32'h0, 0, 0, 1, 5'd7, 32'h7777, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst RegWrite", {31'd0, RegWrite}, 32'd0);
        check("midrst Write_register", {27'd0, Write_register}, 32'd0);
        check("midrst Write_data", Write_data, 32'd0);
        check("midrst retired", {{(32-CW){1'b0}}, retired}, 32'd0);
        #2;
        reset = 1'b0;
        m_valid = 1'b0;
        m_ret   = '0;
        send(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
